tag_lookup_ctrl: RTL

- Sequencing controller placed in front of the tag lookup table (fully or set associative).
- Accepts one lookup request at a time over a valid/ready handshake and drives the table's search port.
- On a miss, allocates a cache block. Cold slots are used first; once the cache is full, the replacement policy's victim is removed with rmen and the new tag is then written with wren.
- Returns hit/miss, cache block address and eviction information to the cache datapath.

---
 rtl/tag_lookup_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/tag_lookup_ctrl.sv
// Sequencing controller in front of the tag lookup table: search, then allocate on a miss.
// Optional hit/miss/evict counters are built when TAG_LOOKUP_CTRL_STATS_EN is defined.
module tag_lookup_ctrl #(
    parameter int BW_ACCESS_ADDR     = 24,
    parameter int N_CAPACITY_BLOCKS  = 128,
    parameter int LOOKUP_LATENCY     = 1,
    localparam int BW_CAPACITY_BLOCKS = $clog2(N_CAPACITY_BLOCKS)
) (
    input  logic                          clock_i,
    input  logic                          resetn_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [BW_ACCESS_ADDR-1:0]     req_addr_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_hit_o,
    output logic [BW_CAPACITY_BLOCKS-1:0] rsp_cache_addr_o,
    output logic                          rsp_evict_o,
    output logic [BW_ACCESS_ADDR-1:0]     rsp_evict_addr_o,
`ifdef TAG_LOOKUP_CTRL_STATS_EN
    output logic [31:0]                   stat_hits_o,
    output logic [31:0]                   stat_misses_o,
    output logic [31:0]                   stat_evicts_o,
`endif
    input  logic [BW_CAPACITY_BLOCKS-1:0] victim_cache_addr_i,
    input  logic [BW_ACCESS_ADDR-1:0]     victim_access_addr_i,
    output logic [BW_ACCESS_ADDR-1:0]     tlt_search_addr_o,
    input  logic                          tlt_hit_i,
    input  logic [BW_CAPACITY_BLOCKS-1:0] tlt_cache_addr_i,
    output logic                          tlt_wren_o,
    output logic                          tlt_rmen_o,
    output logic [BW_ACCESS_ADDR-1:0]     tlt_write_addr_o,
    output logic [BW_CAPACITY_BLOCKS-1:0] tlt_cache_addr_o,
    output logic [2:0]                    dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and payload stays stable while valid is high.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        RESOLVE = 3'd2,
        EVICT   = 3'd3,
        FILL    = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(LOOKUP_LATENCY - 1);
    localparam logic [BW_CAPACITY_BLOCKS-1:0] FILL_LAST = BW_CAPACITY_BLOCKS'(N_CAPACITY_BLOCKS - 1);

    state_t                          state;
    state_t                          next_state;
    logic [2:0]                      wait_cnt;
    logic                            hit_q;
    logic [BW_CAPACITY_BLOCKS-1:0]   lookup_addr_q;
    logic [BW_ACCESS_ADDR-1:0]       req_addr_q;
    logic [BW_CAPACITY_BLOCKS-1:0]   slot_q;
    logic [BW_ACCESS_ADDR-1:0]       victim_addr_q;
    logic [BW_CAPACITY_BLOCKS-1:0]   fill_cnt;
    logic                            full;
    logic                            rsp_done;

    assign rsp_done    = rsp_valid_o && rsp_ready_i;
    assign dbg_state_o = state;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid_i && req_ready_o) next_state = SEARCH;
            SEARCH:  if (wait_cnt == WAIT_LAST) next_state = RESOLVE;
            RESOLVE: begin
                if (hit_q)     next_state = RESP;
                else if (full) next_state = EVICT;
                else           next_state = FILL;
            end
            EVICT:   next_state = FILL;
            FILL:    next_state = RESP;
            RESP:    if (rsp_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            req_ready_o       <= 1'b1;
            rsp_valid_o       <= 1'b0;
            rsp_hit_o         <= 1'b0;
            rsp_cache_addr_o  <= '0;
            rsp_evict_o       <= 1'b0;
            rsp_evict_addr_o  <= '0;
            tlt_search_addr_o <= '0;
            tlt_wren_o        <= 1'b0;
            tlt_rmen_o        <= 1'b0;
            tlt_write_addr_o  <= '0;
            tlt_cache_addr_o  <= '0;
            wait_cnt          <= '0;
            hit_q             <= 1'b0;
            lookup_addr_q     <= '0;
            req_addr_q        <= '0;
            slot_q            <= '0;
            victim_addr_q     <= '0;
            fill_cnt          <= '0;
            full              <= 1'b0;
        end else begin
            // Registered controls are derived from the state being left, so each pulse lasts one cycle.
            req_ready_o <= (next_state == IDLE);
            rsp_valid_o <= (state == RESP) && (next_state == RESP);
            tlt_rmen_o  <= (state == EVICT);
            tlt_wren_o  <= (state == FILL);
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_addr_q        <= req_addr_i;
                        tlt_search_addr_o <= req_addr_i;
                        wait_cnt          <= '0;
                    end
                end
                SEARCH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        hit_q         <= tlt_hit_i;
                        lookup_addr_q <= tlt_cache_addr_i;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESOLVE: begin
                    rsp_hit_o        <= hit_q;
                    rsp_evict_addr_o <= '0;
                    rsp_evict_o      <= 1'b0;
                    if (hit_q) begin
                        rsp_cache_addr_o <= lookup_addr_q;
                    end else if (full) begin
                        slot_q           <= victim_cache_addr_i;
                        victim_addr_q    <= victim_access_addr_i;
                        rsp_evict_addr_o <= victim_access_addr_i;
                        rsp_evict_o      <= 1'b1;
                    end else begin
                        slot_q <= fill_cnt;
                    end
                end
                EVICT: begin
                    tlt_write_addr_o <= victim_addr_q;
                    tlt_cache_addr_o <= slot_q;
                end
                FILL: begin
                    tlt_write_addr_o <= req_addr_q;
                    tlt_cache_addr_o <= slot_q;
                    rsp_hit_o        <= 1'b0;
                    rsp_cache_addr_o <= slot_q;
                    // Cold slots are handed out in order; the wrap marks the cache as full for good.
                    if (!full) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == FILL_LAST) full <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TAG_LOOKUP_CTRL_STATS_EN
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
            stat_evicts_o <= '0;
        end else if (state == RESP && rsp_done) begin
            if (rsp_hit_o) begin
                if (stat_hits_o != 32'hFFFF_FFFF) stat_hits_o <= stat_hits_o + 32'd1;
            end else begin
                if (stat_misses_o != 32'hFFFF_FFFF) stat_misses_o <= stat_misses_o + 32'd1;
            end
            if (rsp_evict_o && stat_evicts_o != 32'hFFFF_FFFF) stat_evicts_o <= stat_evicts_o + 32'd1;
        end
    end
`endif

endmodule
